// File: rtl/vga_rect_writer.sv
// ============================================================================
// vga_rect_writer: rectangle-fill pixel stream for the VGA adapter draw port.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_rect_writer #(
  parameter int nX       = 10,
  parameter int nY       = 9,
  parameter int COLOR_W  = 9,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [nX-1:0]      x0,
  input  logic [nY-1:0]      y0,
  input  logic [nX-1:0]      width,
  input  logic [nY-1:0]      height,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [nX-1:0]      x,
  output logic [nY-1:0]      y,
  output logic [COLOR_W-1:0] color,
  output logic               write
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [nX:0]   c_screen_w = SCREEN_W[nX:0];
  localparam logic [nY:0]   c_screen_h = SCREEN_H[nY:0];
  localparam logic [nX-1:0] c_one_x    = {{(nX-1){1'b0}}, 1'b1};
  localparam logic [nY-1:0] c_one_y    = {{(nY-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [nX-1:0]        r_cx;
  logic [nY-1:0]        r_cy;
  logic [nX-1:0]        r_x0;
  logic [nY-1:0]        r_y0;
  logic [nX-1:0]        r_width;
  logic [nY-1:0]        r_height;
  logic [COLOR_W-1:0]   r_color;

  state_t               w_next_state;
  logic [nX-1:0]        w_next_cx;
  logic [nY-1:0]        w_next_cy;
  logic [nX-1:0]        w_org_x;
  logic [nY-1:0]        w_org_y;
  logic [COLOR_W-1:0]   w_color;
  logic                 w_load;
  logic                 w_present;
  logic                 w_done;
  logic                 w_col_end;
  logic                 w_last;
  logic [nX:0]          w_sum_x;
  logic [nY:0]          w_sum_y;
  logic                 w_visible;

  assign w_col_end = (r_cx == r_width - c_one_x);
  assign w_last    = w_col_end && (r_cy == r_height - c_one_y);

  // Next-state logic also selects which pixel (if any) is launched at the edge.
  always_comb begin
    w_next_state = r_state;
    w_next_cx    = r_cx;
    w_next_cy    = r_cy;
    w_org_x      = r_x0;
    w_org_y      = r_y0;
    w_color      = r_color;
    w_load       = 1'b0;
    w_present    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load    = 1'b1;
          w_org_x   = x0;
          w_org_y   = y0;
          w_color   = color_in;
          w_next_cx = '0;
          w_next_cy = '0;
          if ((width == '0) || (height == '0)) begin
            w_next_state = DONE;
            w_done       = 1'b1;
          end else begin
            w_next_state = DRAW;
            w_present    = 1'b1;
          end
        end
      end
      DRAW: begin
        if (abort) begin
          w_next_state = IDLE;
        end else if (w_last) begin
          w_next_state = DONE;
          w_done       = 1'b1;
        end else begin
          w_present = 1'b1;
          if (w_col_end) begin
            w_next_cx = '0;
            w_next_cy = r_cy + c_one_y;
          end else begin
            w_next_cx = r_cx + c_one_x;
          end
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // One extra bit on each sum so off-screen coordinates never alias on-screen.
  assign w_sum_x   = {1'b0, w_org_x} + {1'b0, w_next_cx};
  assign w_sum_y   = {1'b0, w_org_y} + {1'b0, w_next_cy};
  assign w_visible = (w_sum_x < c_screen_w) && (w_sum_y < c_screen_h);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cx     <= '0;
      r_cy     <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_color  <= '0;
      x        <= '0;
      y        <= '0;
      color    <= '0;
      write    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cx    <= w_next_cx;
      r_cy    <= w_next_cy;
      if (w_load) begin
        r_x0     <= x0;
        r_y0     <= y0;
        r_width  <= width;
        r_height <= height;
        r_color  <= color_in;
      end
      // Clipped pixels still update x/y; only write is suppressed.
      if (w_present) begin
        x     <= w_sum_x[nX-1:0];
        y     <= w_sum_y[nY-1:0];
        color <= w_color;
      end
      write <= w_present && w_visible;
      busy  <= (w_next_state != IDLE);
      done  <= w_done;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_rect_writer.sv
// ============================================================================
// tb_vga_rect_writer: directed self-checking bench for vga_rect_writer.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_rect_writer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] x0;
  logic [8:0] y0;
  logic [9:0] width;
  logic [8:0] height;
  logic [8:0] color_in;
  logic       abort;
  logic       busy;
  logic       done;
  logic [9:0] x;
  logic [8:0] y;
  logic [8:0] color;
  logic       write;

  int tests  = 0;
  int failed = 0;

  vga_rect_writer dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .width    (width),
    .height   (height),
    .color_in (color_in),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .x        (x),
    .y        (y),
    .color    (color),
    .write    (write)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Compares the full output bundle {busy,done,write,x,y,color} in one go.
  task automatic chk(input string tag, input logic b, input logic d, input logic w,
                     input int ex, input int ey, input int ec);
    logic [30:0] o;
    logic [30:0] e;
    o = {busy, done, write, x, y, color};
    e = {b, d, w, ex[9:0], ey[8:0], ec[8:0]};
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s: observed b%0b d%0b w%0b x%0d y%0d c%03h expected b%0b d%0b w%0b x%0d y%0d c%03h",
             tag, o[30], o[29], o[28], o[27:18], o[17:9], o[8:0],
             e[30], e[29], e[28], e[27:18], e[17:9], e[8:0]);
    end
  endtask

  task automatic cmd(input int cx0, input int cy0, input int cw, input int ch, input int cc);
    x0       = cx0[9:0];
    y0       = cy0[8:0];
    width    = cw[9:0];
    height   = ch[8:0];
    color_in = cc[8:0];
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    x0 = '0; y0 = '0; width = '0; height = '0; color_in = '0;
    step();
    step();
    chk("reset_state", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    chk("idle_after_reset", 0, 0, 0, 0, 0, 0);

    // Basic 3x2 fill
    cmd(10, 20, 3, 2, 'h1C0);
    x0 = 10'd99; color_in = 9'h005;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("basic_px_r%0d_c%0d", r, c), 1, 0, 1, 10 + c, 20 + r, 'h1C0);
        step();
      end
    chk("basic_done", 1, 1, 0, 12, 21, 'h1C0);
    step();
    chk("basic_idle", 0, 0, 0, 12, 21, 'h1C0);

    // Empty rectangle
    cmd(50, 60, 0, 5, 'h0FF);
    chk("empty_done", 1, 1, 0, 12, 21, 'h1C0);
    step();
    chk("empty_idle", 0, 0, 0, 12, 21, 'h1C0);

    // Clipping at the bottom-right corner
    cmd(638, 479, 4, 2, 'h03F);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("clip_px_r%0d_c%0d", r, c), 1, 0, (r == 0 && c < 2) ? 1'b1 : 1'b0,
            638 + c, 479 + r, 'h03F);
        step();
      end
    chk("clip_done", 1, 1, 0, 641, 480, 'h03F);
    step();
    chk("clip_idle", 0, 0, 0, 641, 480, 'h03F);

    // Start while busy is ignored
    cmd(100, 50, 2, 2, 'h0AA);
    chk("busy_px0", 1, 0, 1, 100, 50, 'h0AA);
    x0 = 10'd5; y0 = 9'd6; width = 10'd7; height = 9'd7; color_in = 9'h155;
    start = 1'b1;
    step();
    chk("busy_px1", 1, 0, 1, 101, 50, 'h0AA);
    step();
    chk("busy_px2", 1, 0, 1, 100, 51, 'h0AA);
    start = 1'b0;
    step();
    chk("busy_px3", 1, 0, 1, 101, 51, 'h0AA);
    step();
    chk("busy_done", 1, 1, 0, 101, 51, 'h0AA);
    step();
    chk("busy_idle0", 0, 0, 0, 101, 51, 'h0AA);
    step();
    chk("busy_idle1", 0, 0, 0, 101, 51, 'h0AA);

    // Abort: abort sampled at the edge that would launch pixel 5
    cmd(200, 100, 4, 4, 'h1FF);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort_px%0d", c), 1, 0, 1, 200 + c, 100, 'h1FF);
      if (c == 3) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    chk("abort_stop", 0, 0, 0, 203, 100, 'h1FF);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort_quiet%0d", i), 0, 0, 0, 203, 100, 'h1FF);
      step();
    end
    cmd(1, 2, 1, 1, 'h007);
    chk("after_abort_px", 1, 0, 1, 1, 2, 'h007);
    step();
    chk("after_abort_done", 1, 1, 0, 1, 2, 'h007);
    step();
    chk("after_abort_idle", 0, 0, 0, 1, 2, 'h007);

    // Reset mid-fill
    cmd(300, 200, 3, 1, 'h0F0);
    chk("rst_px0", 1, 0, 1, 300, 200, 'h0F0);
    step();
    chk("rst_px1", 1, 0, 1, 301, 200, 'h0F0);
    step();
    chk("rst_px2", 1, 0, 1, 302, 200, 'h0F0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_cleared", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_quiet%0d", i), 0, 0, 0, 0, 0, 0);
    end
    cmd(0, 0, 1, 1, 'h111);
    chk("rst_restart_px", 1, 0, 1, 0, 0, 'h111);
    step();
    chk("rst_restart_done", 1, 1, 0, 0, 0, 'h111);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
